unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the IF stage (instruction fetch) and the MA stage (load/store) of the RV32IM pipelined CPU.
- Sequences each access with a 4-state FSM against the memory's busywait handshake.
- Produces per-port stall signals that the hazard unit uses to freeze the pipeline.
- Data accesses have priority, with a bounded starvation guard for fetch.

Parameters:
- STARVE_LIMIT, 4: consecutive MA grants allowed while IF_REQ is pending before IF is forced a grant (1..15).
- TIMEOUT, 64: max cycles MEM_BUSYWAIT may stay high in one access before abort.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- IF_REQ  in  1  fetch request; held until IF_VALID.
- IF_ADDR  in  32  fetch word address (PC).
- IF_RDATA  out  32  fetched instruction, registered.
- IF_VALID  out  1  one-cycle completion pulse for fetch.
- IF_STALL  out  1  IF_REQ & ~IF_VALID (combinational).
- MA_READ  in  1  load request; held until MA_VALID.
- MA_WRITE  in  1  store request; held until MA_VALID.
- MA_ADDR  in  32  data address.
- MA_WDATA  in  32  store data.
- MA_RDATA  out  32  load data, registered.
- MA_VALID  out  1  one-cycle completion pulse for data.
- MA_STALL  out  1  (MA_READ|MA_WRITE) & ~MA_VALID (combinational).
- MEM_READ  out  1  memory read strobe, registered.
- MEM_WRITE  out  1  memory write strobe, registered.
- MEM_ADDR  out  32  memory address, registered.
- MEM_WDATA  out  32  memory write data, registered.
- MEM_RDATA  in  32  memory read data; valid when MEM_BUSYWAIT=0 while strobe high.
- MEM_BUSYWAIT  in  1  memory not ready.
- MEM_ERR  out  1  sticky timeout flag; cleared only by RESET.

Behaviour:
- Reset (sync, active-high):
  - state=IDLE.
  - All outputs 0: strobes, VALIDs, RDATAs, MEM_ADDR/WDATA, MEM_ERR.
  - Starvation and timeout counters cleared.
  - Reset mid-access drops the strobes at that edge; no VALID is issued.
- States: IDLE, I_ACC, D_ACC, DONE.
- IDLE, at each edge, grant selection:
  - MA pending and (starve_cnt < STARVE_LIMIT or ~IF_REQ) -> D_ACC.
  - Else IF_REQ -> I_ACC.
  - Else stay in IDLE.
  - On grant, register MEM_ADDR and strobes; for D_ACC also MEM_WDATA.
  - MA_READ & MA_WRITE together: treated as write; the read is ignored.
- I_ACC / D_ACC:
  - Strobes and address stay stable.
  - At an edge with MEM_BUSYWAIT=0:
    - Capture MEM_RDATA into IF_RDATA (I_ACC) or MA_RDATA (D_ACC load only; a store leaves MA_RDATA unchanged).
    - Drop strobes, assert the matching VALID, go to DONE.
  - tmo_cnt increments each cycle with MEM_BUSYWAIT=1. At an edge where tmo_cnt = TIMEOUT-1 and busywait is still high:
    - Abort the access; the RDATA target is loaded with 0.
    - Set MEM_ERR, pulse VALID, go to DONE.
- DONE:
  - VALID high for exactly this one cycle; requests are ignored this cycle.
  - Next edge -> IDLE with VALID=0.
  - Minimum access is 3 cycles: request seen, zero-wait memory, VALID.
- Starvation counter:
  - Increments on each D_ACC grant while IF_REQ=1, saturating at STARVE_LIMIT.
  - Clears on an I_ACC grant or any edge with IF_REQ=0.
- Invariants:
  - MEM_READ and MEM_WRITE are never both high.
  - IF_VALID and MA_VALID are never both high.
  - Strobes are high only in I_ACC/D_ACC.

Test Plan:
- Reset then IF_REQ=1, IF_ADDR=0x00000010, memory zero-wait returns 0x00500093 -> MEM_READ high in cycle 1, IF_VALID and IF_RDATA=0x00500093 in cycle 2, IF_STALL=0 in cycle 2 only.
- IF_REQ and MA_READ (addr 0x100) raised in the same cycle, busywait 2 cycles -> data served first (MEM_ADDR=0x100), MA_VALID at cycle 4; fetch granted at next IDLE, IF_VALID 4 cycles later.
- MA_WRITE addr 0x200 data 0xDEADBEEF with busywait 3 cycles -> MEM_WRITE=1, MEM_WDATA=0xDEADBEEF stable for 4 cycles; MA_VALID pulse; MA_RDATA unchanged; MEM_READ never high.
- STARVE_LIMIT=4: IF_REQ held, back-to-back loads -> 4 data grants, then the 5th grant goes to IF even though MA is pending.
- TIMEOUT=64, MEM_BUSYWAIT stuck high on a fetch -> abort after 64 busy cycles: IF_VALID=1, IF_RDATA=0, MEM_ERR=1 and stays set until RESET.
- RESET asserted during D_ACC with busywait high -> next edge: all strobes 0, state IDLE, no MA_VALID; a new fetch afterwards completes normally.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Arbiter that shares one single-port instruction/data memory between the fetch (IF)
// and load/store (MA) ports. Data accesses have priority, and a bounded guard keeps fetch from starving.
module unified_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IF_REQ,
  input  logic [31:0] IF_ADDR,
  output logic [31:0] IF_RDATA,
  output logic        IF_VALID,
  output logic        IF_STALL,
  input  logic        MA_READ,
  input  logic        MA_WRITE,
  input  logic [31:0] MA_ADDR,
  input  logic [31:0] MA_WDATA,
  output logic [31:0] MA_RDATA,
  output logic        MA_VALID,
  output logic        MA_STALL,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_BUSYWAIT,
  output logic        MEM_ERR
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [3:0]    STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC, DONE} state_t;

  state_t        state_reg, state_next;
  logic          mem_read_reg, mem_read_next;
  logic          mem_write_reg, mem_write_next;
  logic [31:0]   mem_addr_reg, mem_addr_next;
  logic [31:0]   mem_wdata_reg, mem_wdata_next;
  logic [31:0]   if_rdata_reg, if_rdata_next;
  logic [31:0]   ma_rdata_reg, ma_rdata_next;
  logic          if_valid_reg, if_valid_next;
  logic          ma_valid_reg, ma_valid_next;
  logic          mem_err_reg, mem_err_next;
  logic [3:0]    starve_reg, starve_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic          ma_pend;
  logic [31:0]   fill_data;

  assign ma_pend = MA_READ | MA_WRITE;

  always_comb begin
    state_next     = state_reg;
    mem_read_next  = mem_read_reg;
    mem_write_next = mem_write_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    if_rdata_next  = if_rdata_reg;
    ma_rdata_next  = ma_rdata_reg;
    if_valid_next  = 1'b0;
    ma_valid_next  = 1'b0;
    mem_err_next   = mem_err_reg;
    starve_next    = starve_reg;
    tmo_next       = tmo_reg;
    fill_data      = MEM_BUSYWAIT ? 32'd0 : MEM_RDATA;

    case (state_reg)
      IDLE: begin
        if (ma_pend && (starve_reg < STARVE_MAX || !IF_REQ)) begin
          // A simultaneous read+write request is served as a store.
          state_next     = D_ACC;
          mem_write_next = MA_WRITE;
          mem_read_next  = ~MA_WRITE;
          mem_addr_next  = MA_ADDR;
          mem_wdata_next = MA_WDATA;
          tmo_next       = '0;
          if (IF_REQ && starve_reg < STARVE_MAX)
            starve_next = starve_reg + 1'b1;
        end else if (IF_REQ) begin
          state_next    = I_ACC;
          mem_read_next = 1'b1;
          mem_addr_next = IF_ADDR;
          tmo_next      = '0;
          starve_next   = '0;
        end
      end
      I_ACC, D_ACC: begin
        if (!MEM_BUSYWAIT || tmo_reg == TMO_LAST) begin
          // A timed-out access still completes, returning zero; a store has no read target.
          if (MEM_BUSYWAIT)
            mem_err_next = 1'b1;
          if (state_reg == I_ACC) begin
            if_rdata_next = fill_data;
            if_valid_next = 1'b1;
          end else begin
            if (mem_read_reg)
              ma_rdata_next = fill_data;
            ma_valid_next = 1'b1;
          end
          mem_read_next  = 1'b0;
          mem_write_next = 1'b0;
          state_next     = DONE;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (!IF_REQ)
      starve_next = '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg     <= IDLE;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      ma_rdata_reg  <= '0;
      if_valid_reg  <= 1'b0;
      ma_valid_reg  <= 1'b0;
      mem_err_reg   <= 1'b0;
      starve_reg    <= '0;
      tmo_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      mem_read_reg  <= mem_read_next;
      mem_write_reg <= mem_write_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      if_rdata_reg  <= if_rdata_next;
      ma_rdata_reg  <= ma_rdata_next;
      if_valid_reg  <= if_valid_next;
      ma_valid_reg  <= ma_valid_next;
      mem_err_reg   <= mem_err_next;
      starve_reg    <= starve_next;
      tmo_reg       <= tmo_next;
    end
  end

  assign IF_RDATA  = if_rdata_reg;
  assign IF_VALID  = if_valid_reg;
  assign IF_STALL  = IF_REQ & ~if_valid_reg;
  assign MA_RDATA  = ma_rdata_reg;
  assign MA_VALID  = ma_valid_reg;
  assign MA_STALL  = (MA_READ | MA_WRITE) & ~ma_valid_reg;
  assign MEM_READ  = mem_read_reg;
  assign MEM_WRITE = mem_write_reg;
  assign MEM_ADDR  = mem_addr_reg;
  assign MEM_WDATA = mem_wdata_reg;
  assign MEM_ERR   = mem_err_reg;

endmodule
